// File: rtl/id_token_collect_pkg.sv
// Shared encodings for the identifier path: character classes and run-FSM states.
// The recognizer imports the same package, so both blocks classify characters identically.
package id_token_collect_pkg;

  typedef enum logic [1:0] {
    CC_LETTER = 2'd0,
    CC_DIGIT  = 2'd1,
    CC_DELIM  = 2'd2
  } char_cls_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_BAD  = 2'd2
  } run_state_t;

  localparam int TOK_LEN_W = 8;
  localparam int TOK_CNT_W = 16;

endpackage

// File: rtl/id_token_collect_if.sv
// Character stream in, completed-token valid/ready channel and status out.
// The master drives the stream and the consumer's ready; the slave is the collector.
interface id_token_collect_if;
  import id_token_collect_pkg::*;

  logic [7:0]           char;
  logic                 match;
  logic                 tok_ready;
  logic                 tok_valid;
  logic [TOK_LEN_W-1:0] tok_len;
  logic [TOK_CNT_W-1:0] tok_cnt;
  logic                 ovf;

  modport master (
    output char, match, tok_ready,
    input  tok_valid, tok_len, tok_cnt, ovf
  );

  modport slave (
    input  char, match, tok_ready,
    output tok_valid, tok_len, tok_cnt, ovf
  );
endinterface

// File: rtl/id_token_collect_char_class.sv
// Combinational ASCII classifier: letter, digit or delimiter.
// Zero latency, no state; shared with the recognizer.
module char_class
  import id_token_collect_pkg::*;
(
  input  logic [7:0] i_char,
  output char_cls_t  o_cls
);

  always_comb begin
    o_cls = CC_DELIM;
    if ((i_char >= 8'h41 && i_char <= 8'h5A) || (i_char >= 8'h61 && i_char <= 8'h7A))
      o_cls = CC_LETTER;
    else if (i_char >= 8'h30 && i_char <= 8'h39)
      o_cls = CC_DIGIT;
  end

endmodule

// File: rtl/id_token_collect.sv
// Collects identifier tokens ending in a digit; token appears one cycle after its delimiter.
// A token completing while the output slot is held by an unaccepted token is dropped and ovf set.
module id_token_collect
  import id_token_collect_pkg::*;
#(
  parameter int LEN_MAX = 255
) (
  input logic               clk,
  input logic               reset,
  id_token_collect_if.slave bus
);

  localparam logic [TOK_LEN_W-1:0] LEN_SAT = TOK_LEN_W'(LEN_MAX);

  char_cls_t            w_cls;
  logic                 w_done;
  logic                 w_slot_free;
  run_state_t           r_state;
  logic [TOK_LEN_W-1:0] r_run_len;
  logic [TOK_LEN_W-1:0] r_tok_len;
  logic [TOK_CNT_W-1:0] r_tok_cnt;
  logic                 r_tok_valid;
  logic                 r_ovf;

  char_class u_char_class (
    .i_char (bus.char),
    .o_cls  (w_cls)
  );

  // The recognizer's match only counts when our own run FSM agrees a run is in progress.
  assign w_done      = (r_state == ST_RUN) && bus.match && (w_cls == CC_DELIM);
  assign w_slot_free = !r_tok_valid || bus.tok_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_run_len   <= '0;
      r_tok_valid <= 1'b0;
      r_tok_len   <= '0;
      r_tok_cnt   <= '0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cls == CC_LETTER) begin
            r_state   <= ST_RUN;
            r_run_len <= TOK_LEN_W'(1);
          end else if (w_cls == CC_DIGIT) begin
            r_state <= ST_BAD;
          end
        end
        ST_RUN: begin
          if (w_cls == CC_DELIM)
            r_state <= ST_IDLE;
          else if (r_run_len < LEN_SAT)
            r_run_len <= r_run_len + TOK_LEN_W'(1);
        end
        ST_BAD: begin
          if (w_cls == CC_DELIM)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_done) begin
        if (r_tok_cnt != {TOK_CNT_W{1'b1}})
          r_tok_cnt <= r_tok_cnt + TOK_CNT_W'(1);
        if (w_slot_free) begin
          r_tok_valid <= 1'b1;
          r_tok_len   <= r_run_len;
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (r_tok_valid && bus.tok_ready) begin
        r_tok_valid <= 1'b0;
      end
    end
  end

  assign bus.tok_valid = r_tok_valid;
  assign bus.tok_len   = r_tok_len;
  assign bus.tok_cnt   = r_tok_cnt;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_id_token_collect.sv
// Directed bench for id_token_collect: hand-computed expectations checked with immediate assertions.
module tb_id_token_collect;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  id_token_collect_if bus ();

  id_token_collect #(.LEN_MAX(255)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one character for one clock edge, then settle just after the edge.
  task automatic step(input logic [7:0] c, input logic m, input logic r);
    bus.char      = c;
    bus.match     = m;
    bus.tok_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.char      = 8'h20;
    bus.match     = 1'b0;
    bus.tok_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_valid", 16'(bus.tok_valid), 16'd0);
    chk("rst_len",   16'(bus.tok_len),   16'd0);
    chk("rst_cnt",   bus.tok_cnt,        16'd0);
    chk("rst_ovf",   16'(bus.ovf),       16'd0);
    reset = 1'b0;

    // "a1 " with match at the space, consumer ready
    step("a", 1'b0, 1'b1);
    step("1", 1'b0, 1'b1);
    step(" ", 1'b1, 1'b1);
    chk("a1_valid", 16'(bus.tok_valid), 16'd1);
    chk("a1_len",   16'(bus.tok_len),   16'd2);
    chk("a1_cnt",   bus.tok_cnt,        16'd1);
    step(" ", 1'b0, 1'b1);
    chk("a1_drain_valid", 16'(bus.tok_valid), 16'd0);
    chk("a1_drain_len",   16'(bus.tok_len),   16'd2);

    // "ab " ends in a letter: no match, no token
    step("a", 1'b0, 1'b1);
    step("b", 1'b0, 1'b1);
    step(" ", 1'b0, 1'b1);
    chk("ab_valid", 16'(bus.tok_valid), 16'd0);
    chk("ab_cnt",   bus.tok_cnt,        16'd1);

    // "1a2 " is a bad run; a stray match is ignored, then a second delimiter
    step("1", 1'b0, 1'b1);
    step("a", 1'b0, 1'b1);
    step("2", 1'b1, 1'b1);
    step(" ", 1'b1, 1'b1);
    chk("bad_valid", 16'(bus.tok_valid), 16'd0);
    chk("bad_cnt",   bus.tok_cnt,        16'd1);
    chk("bad_ovf",   16'(bus.ovf),       16'd0);
    step(" ", 1'b1, 1'b1);
    chk("dd_cnt", bus.tok_cnt, 16'd1);

    // "x9 y7 " with consumer stalled: second token dropped
    pulse_reset();
    step("x", 1'b0, 1'b0);
    step("9", 1'b0, 1'b0);
    step(" ", 1'b1, 1'b0);
    chk("x9_valid", 16'(bus.tok_valid), 16'd1);
    chk("x9_len",   16'(bus.tok_len),   16'd2);
    chk("x9_cnt",   bus.tok_cnt,        16'd1);
    step("y", 1'b0, 1'b0);
    step("7", 1'b0, 1'b0);
    step(" ", 1'b1, 1'b0);
    chk("drop_valid", 16'(bus.tok_valid), 16'd1);
    chk("drop_len",   16'(bus.tok_len),   16'd2);
    chk("drop_ovf",   16'(bus.ovf),       16'd1);
    chk("drop_cnt",   bus.tok_cnt,        16'd2);
    step(" ", 1'b0, 1'b1);
    chk("hs_valid", 16'(bus.tok_valid), 16'd0);
    chk("hs_ovf",   16'(bus.ovf),       16'd1);

    // Letter plus 300 digits saturates the length at 255
    step("q", 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) step("5", 1'b0, 1'b1);
    step(" ", 1'b1, 1'b1);
    chk("sat_valid", 16'(bus.tok_valid), 16'd1);
    chk("sat_len",   16'(bus.tok_len),   16'd255);
    chk("sat_cnt",   bus.tok_cnt,        16'd3);
    chk("sat_ovf",   16'(bus.ovf),       16'd1);

    // "ab3", reset mid-run, then "4 ": the run is discarded
    step("a", 1'b0, 1'b1);
    step("b", 1'b0, 1'b1);
    step("3", 1'b0, 1'b1);
    chk("pre_rst_len", 16'(bus.tok_len), 16'd255);
    #2;
    reset = 1'b1;
    #2;
    chk("mid_rst_len", 16'(bus.tok_len), 16'd0);
    chk("mid_rst_cnt", bus.tok_cnt,      16'd0);
    chk("mid_rst_ovf", 16'(bus.ovf),     16'd0);
    reset = 1'b0;
    step("4", 1'b0, 1'b1);
    step(" ", 1'b1, 1'b1);
    chk("post_valid", 16'(bus.tok_valid), 16'd0);
    chk("post_len",   16'(bus.tok_len),   16'd0);
    chk("post_cnt",   bus.tok_cnt,        16'd0);
    chk("post_ovf",   16'(bus.ovf),       16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
